// File: rtl/shiftreg_pkg.sv
// Shared sizing helpers for the tapped shift register: tap address and occupancy-count widths.
package shiftreg_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((r < 32) && ((32'd1 << r) < n)) begin
      r = r + 1;
    end
    return r;
  endfunction

  // A tap port needs at least one bit even when clog2 collapses to zero.
  function automatic int unsigned tap_aw(input int unsigned depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int unsigned count_w(input int unsigned depth);
    return tap_aw(depth) + 1;
  endfunction

endpackage

// File: rtl/shiftreg_srl_bit.sv
// One DEPTH-long bit column with a dynamic tap and a fixed last-stage output.
// Left unreset so it maps onto shift-register LUT primitives.
module shiftreg_srl_bit #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          CLK,
  input  logic          en_i,
  input  logic          d_i,
  input  logic [AW-1:0] addr_i,
  output logic          tap_o,
  output logic          last_o
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge CLK) begin
    if (en_i) begin
      sr_q <= {sr_q[DEPTH-2:0], d_i};
    end
  end

  assign tap_o  = sr_q[addr_i];
  assign last_o = sr_q[DEPTH-1];

endmodule

// File: rtl/shiftreg_tap.sv
// Tapped shift register: WIDTH bit columns of DEPTH stages with per-stage valid tracking,
// a saturating occupancy count, and zero-masked tap/last outputs.
module shiftreg_tap
  import shiftreg_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW   = tap_aw(DEPTH),
  localparam int unsigned CW   = count_w(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             writeEnable,
  input  logic [WIDTH-1:0] writeData,
  input  logic             flush,
  input  logic [AW-1:0]    tapAddr,
  output logic [WIDTH-1:0] readData,
  output logic             readValid,
  output logic [WIDTH-1:0] lastData,
  output logic             lastValid,
  output logic [CW-1:0]    count,
  output logic             full
);

  localparam logic [CW-1:0] DepthCount = CW'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] tap_col, last_col;
  logic             tap_in_range;

  for (genvar i = 0; i < WIDTH; i++) begin : g_col
    shiftreg_srl_bit #(
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_col (
      .CLK    (CLK),
      .en_i   (writeEnable),
      .d_i    (writeData[i]),
      .addr_i (tapAddr),
      .tap_o  (tap_col[i]),
      .last_o (last_col[i])
    );
  end

  // Flush is applied before the write so a simultaneous write lands in an empty register.
  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
    if (writeEnable) begin
      valid_d = {valid_d[DEPTH-2:0], 1'b1};
      if (count_d != DepthCount) begin
        count_d = count_d + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    tap_in_range = (32'(tapAddr) < DEPTH);
    readValid    = tap_in_range && valid_q[tapAddr];
    readData     = readValid ? tap_col : '0;
    lastValid    = valid_q[DEPTH-1];
    lastData     = lastValid ? last_col : '0;
    count        = count_q;
    full         = (count_q == DepthCount);
  end

endmodule
